rl_ram_1rw_arb: RTL and testbench
=================================

RL_RAM_1RW_ARB -- requirements
Module: rl_ram_1rw_arb

Interface
REQ-001 Parameter ABITS, default 10: RAM address width in bits.
REQ-002 Parameter DBITS, default 32: RAM data width in bits; BEBITS = (DBITS+7)/8.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole RAM after reset; 0 = skip the fill.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 req_i  in  2  per-port access request (bit k = port k).
REQ-007 we_i  in  2  per-port write enable; 0 = read.
REQ-008 addr_i  in  2*ABITS  per-port address (port k at [k*ABITS+:ABITS]).
REQ-009 be_i  in  2*BEBITS  per-port byte enables.
REQ-010 wdata_i  in  2*DBITS  per-port write data.
REQ-011 gnt_o  out  2  per-port grant; request accepted this cycle.
REQ-012 rvalid_o  out  2  per-port read data valid.
REQ-013 rdata_o  out  DBITS  read data, shared by both ports, qualified by rvalid_o.
REQ-014 init_done_o  out  1  RAM fill complete; ports may be granted.
REQ-015 ram_addr_o  out  ABITS  RAM address.
REQ-016 ram_we_o  out  1  RAM write enable.
REQ-017 ram_be_o  out  BEBITS  RAM byte enables.
REQ-018 ram_din_o  out  DBITS  RAM write data.
REQ-019 ram_dout_i  in  DBITS  RAM registered read data; valid 1 cycle after the address is presented.

Function
REQ-020 FSM states: ST_INIT and ST_RUN; reset enters ST_INIT if CLEAR_ON_RESET=1, otherwise ST_RUN.
REQ-021 ST_INIT drives the following each cycle:
- ram_we_o=1, ram_be_o=all-ones, ram_din_o=0;
- ram_addr_o = ABITS-bit fill counter, starting at 0 and incrementing by 1.
REQ-022 ST_INIT on counter = 2**ABITS-1: write that last address, then go to ST_RUN next cycle; the counter does not wrap.
REQ-023 init_done_o is registered; it is 1 exactly when the state is ST_RUN.
REQ-024 In ST_INIT: gnt_o=0 and rvalid_o=0 regardless of req_i.
REQ-025 ST_RUN grant is combinational from req_i and the priority pointer:
- one requester: that port is granted;
- both: the port the pointer favours is granted;
- none: gnt_o=0.
REQ-026 Exactly one gnt_o bit is high whenever any req_i bit is high in ST_RUN; gnt_o is never 2'b11.
REQ-027 Priority pointer is a 1-bit register, reset value 0 (favours port 0), updated only on a grant.
REQ-028 After a grant to port k, the pointer favours port 1-k, giving strict alternation under continuous contention.
REQ-029 On grant to port k: ram_addr_o, ram_we_o, ram_be_o and ram_din_o take port k's fields in the same cycle.
REQ-030 With no grant in ST_RUN: ram_we_o=0, ram_be_o=0, ram_addr_o=port-0 address, ram_din_o=0.
REQ-031 A granted read (we=0) on port k in cycle N asserts rvalid_o[k] for exactly one cycle in cycle N+1.
REQ-032 rdata_o = ram_dout_i, passed through combinationally.
REQ-033 Granted writes produce no rvalid_o pulse.
REQ-034 Back-to-back grants are allowed every cycle, giving one access per cycle of throughput.
REQ-035 Responses have no backpressure; a requester must accept data while its rvalid_o bit is 1.
REQ-036 A requester holds req/we/addr/be/wdata stable until it sees gnt_o; the block does not queue requests.

Reset
REQ-037 Synchronous reset (rst_i=1 at a clock edge) sets:
- gnt_o=0, rvalid_o=0, init_done_o=0;
- pointer=0, fill counter=0, ram_we_o=0.
REQ-038 Reset mid-fill or mid-read drops any pending rvalid_o pulse and restarts the fill from address 0.
REQ-039 On the first cycle after reset deasserts, the block enters the reset-selected state (REQ-020).

Structure
REQ-040 Shared package rl_ram_arb_pkg holds the state enum type (ST_INIT, ST_RUN) and the constant NPORTS=2.
REQ-041 The two-way round-robin arbiter (REQ-025 to REQ-028) is sub-module rl_rr_arb2, with ports clk_i, rst_i, req_i[1:0], gnt_o[1:0].
REQ-042 The block does not instantiate the RAM; the parent connects the ram_* ports to a 1RW byte-enabled RAM with 1-cycle registered read.

Verification
REQ-043 Bench configuration: ABITS=4, DBITS=32, CLEAR_ON_RESET=1, with a 1RW RAM model; every bench follows this configuration unless a scenario states otherwise.
REQ-044 Fill:
- release reset, req_i=2'b11 held -> ram_we_o=1 for 16 cycles at addresses 0..15, gnt_o=0 throughout;
- init_done_o=1 in cycle 17, then grants begin.
REQ-045 Write then read:
- port0 writes addr 3 = 32'hDEADBEEF with be=4'b1111;
- port1 reads addr 3 -> rvalid_o=2'b10 one cycle after the grant, rdata_o=32'hDEADBEEF.
REQ-046 Byte enables: port0 writes addr 5 = 32'hAABBCCDD with be=4'b0101, then reads addr 5 -> rdata_o=32'h00BB00DD.
REQ-047 Contention: both ports read continuously for 6 cycles from reset pointer -> gnt_o = 01,10,01,10,01,10; each rvalid_o bit pulses 3 times, one cycle after its grant.
REQ-048 Reset mid-fill: assert rst_i at fill address 7 -> next cycle rvalid_o=0 and init_done_o=0, then the fill restarts at address 0 and runs 16 cycles.
REQ-049 CLEAR_ON_RESET=0:
- init_done_o=1 on the first cycle after reset;
- a port0 read of addr 0 is granted in that same cycle, with rvalid_o[0]=1 the following cycle.

Source files
------------

// File: rtl/rl_ram_arb_pkg.sv
// rtl/rl_ram_arb_pkg.sv - shared types and constants for the 1RW RAM arbiter
package rl_ram_arb_pkg;

  localparam int NPORTS = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rl_rr_arb2.sv
// rtl/rl_rr_arb2.sv - two-way round-robin arbiter with a 1-bit priority pointer
module rl_rr_arb2
  import rl_ram_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORTS-1:0] req_i,
  output logic [NPORTS-1:0] gnt_o
);

  // 0 favours port 0, 1 favours port 1
  logic ptr_q;

  // Grant the sole requester, or the favoured one when both ask
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Point away from whichever port was just served
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/rl_ram_1rw_arb.sv
// rtl/rl_ram_1rw_arb.sv - two-port front end for a single 1RW RAM with post-reset zero fill
module rl_ram_1rw_arb
  import rl_ram_arb_pkg::*;
#(
  parameter  int ABITS          = 10,
  parameter  int DBITS          = 32,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int BEBITS         = (DBITS + 7) / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NPORTS-1:0]        req_i,
  input  logic [NPORTS-1:0]        we_i,
  input  logic [NPORTS*ABITS-1:0]  addr_i,
  input  logic [NPORTS*BEBITS-1:0] be_i,
  input  logic [NPORTS*DBITS-1:0]  wdata_i,
  output logic [NPORTS-1:0]        gnt_o,
  output logic [NPORTS-1:0]        rvalid_o,
  output logic [DBITS-1:0]         rdata_o,
  output logic                     init_done_o,
  output logic [ABITS-1:0]         ram_addr_o,
  output logic                     ram_we_o,
  output logic [BEBITS-1:0]        ram_be_o,
  output logic [DBITS-1:0]         ram_din_o,
  input  logic [DBITS-1:0]         ram_dout_i
);

  localparam state_t          RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ABITS-1:0] FILL_LAST = '1;

  state_t              state_q;
  logic [ABITS-1:0]    fill_cnt_q;
  logic                init_done_q;
  logic [NPORTS-1:0]   rvalid_q;
  logic                run;
  logic                sel;
  logic [NPORTS-1:0]   arb_req;
  logic [NPORTS-1:0]   arb_gnt;

  // Ports only compete once the fill is over and reset is released
  assign run     = (state_q == ST_RUN) && !rst_i;
  assign arb_req = req_i & {NPORTS{run}};
  assign sel     = arb_gnt[1];

  rl_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (arb_req),
    .gnt_o (arb_gnt)
  );

  assign gnt_o       = arb_gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_dout_i;
  assign init_done_o = init_done_q;

  // RAM command mux: fill writes during init, otherwise the granted port's fields
  always_comb begin
    ram_we_o   = 1'b0;
    ram_be_o   = '0;
    ram_din_o  = '0;
    ram_addr_o = addr_i[0 +: ABITS];
    if (!rst_i && state_q == ST_INIT) begin
      ram_we_o   = 1'b1;
      ram_be_o   = '1;
      ram_addr_o = fill_cnt_q;
    end else if (|arb_gnt) begin
      ram_we_o   = sel ? we_i[1] : we_i[0];
      ram_be_o   = sel ? be_i[BEBITS +: BEBITS] : be_i[0 +: BEBITS];
      ram_din_o  = sel ? wdata_i[DBITS +: DBITS] : wdata_i[0 +: DBITS];
      ram_addr_o = sel ? addr_i[ABITS +: ABITS] : addr_i[0 +: ABITS];
    end
  end

  // Init/run sequencing, fill counter and one-cycle read-valid pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RST_STATE;
      fill_cnt_q  <= '0;
      init_done_q <= (RST_STATE == ST_RUN);
      rvalid_q    <= '0;
    end else begin
      rvalid_q <= arb_gnt & ~we_i;
      case (state_q)
        ST_INIT: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= RST_STATE;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rl_ram_1rw_arb.sv
// tb/tb_rl_ram_1rw_arb.sv - directed bench for rl_ram_1rw_arb with 1RW RAM models
module tb_rl_ram_1rw_arb;

  localparam int ABITS  = 4;
  localparam int DBITS  = 32;
  localparam int BEBITS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance (zero fill enabled)
  logic              rst;
  logic [1:0]        req, we;
  logic [ABITS-1:0]  a0, a1;
  logic [BEBITS-1:0] b0, b1;
  logic [DBITS-1:0]  d0, d1;
  logic [1:0]        gnt, rvalid;
  logic [DBITS-1:0]  rdata, ram_din, ram_dout;
  logic              init_done, ram_we;
  logic [ABITS-1:0]  ram_addr;
  logic [BEBITS-1:0] ram_be;

  rl_ram_1rw_arb #(.ABITS(ABITS), .DBITS(DBITS), .CLEAR_ON_RESET(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i({a1, a0}), .be_i({b1, b0}), .wdata_i({d1, d0}),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .init_done_o(init_done),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  logic [DBITS-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BEBITS; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    ram_dout <= mem[ram_addr];
  end

  // Second instance (no fill)
  logic              rst_nc;
  logic [1:0]        req_nc;
  logic [ABITS-1:0]  a0_nc;
  logic [1:0]        gnt_nc, rvalid_nc;
  logic [DBITS-1:0]  rdata_nc, ram_din_nc, ram_dout_nc;
  logic              init_done_nc, ram_we_nc;
  logic [ABITS-1:0]  ram_addr_nc;
  logic [BEBITS-1:0] ram_be_nc;

  rl_ram_1rw_arb #(.ABITS(ABITS), .DBITS(DBITS), .CLEAR_ON_RESET(0)) u_dut_nc (
    .clk_i(clk), .rst_i(rst_nc), .req_i(req_nc), .we_i(2'b00),
    .addr_i({4'd0, a0_nc}), .be_i(8'h00), .wdata_i(64'd0),
    .gnt_o(gnt_nc), .rvalid_o(rvalid_nc), .rdata_o(rdata_nc), .init_done_o(init_done_nc),
    .ram_addr_o(ram_addr_nc), .ram_we_o(ram_we_nc), .ram_be_o(ram_be_nc),
    .ram_din_o(ram_din_nc), .ram_dout_i(ram_dout_nc)
  );

  logic [DBITS-1:0] mem_nc [16];
  initial mem_nc[0] = 32'h12345678;
  always @(posedge clk) begin
    if (ram_we_nc) begin
      for (int b = 0; b < BEBITS; b++) begin
        if (ram_be_nc[b]) mem_nc[ram_addr_nc][8*b +: 8] <= ram_din_nc[8*b +: 8];
      end
    end
    ram_dout_nc <= mem_nc[ram_addr_nc];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g, prev_g;

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; d0 = '0; d1 = '0;
    rst_nc = 1'b1; req_nc = 2'b00; a0_nc = '0;
    tick; tick;

    // Reset state
    check("rst_gnt", gnt, 2'b00);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);

    // Zero fill with both ports requesting
    rst = 1'b0; req = 2'b11; a0 = 4'd1; a1 = 4'd2;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_we", ram_we, 1'b1);
      check("fill_addr", ram_addr, i);
      check("fill_be", ram_be, 4'hF);
      check("fill_din", ram_din, 32'd0);
      check("fill_gnt", gnt, 2'b00);
      check("fill_init_done", init_done, 1'b0);
      tick;
    end

    // Contention from the reset pointer, starting in cycle 17
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 0) check("init_done_17", init_done, 1'b1);
      check("cont_rvalid", rvalid, prev_g);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_gnt", gnt, exp_g);
      check("cont_addr", ram_addr, (exp_g == 2'b01) ? 4'd1 : 4'd2);
      check("cont_we", ram_we, 1'b0);
      prev_g = exp_g;
      tick;
    end
    req = 2'b00;
    #1;
    check("cont_last_rvalid", rvalid, 2'b10);
    check("cont_rdata_zero", rdata, 32'd0);
    tick;
    check("cont_rvalid_idle", rvalid, 2'b00);

    // Port 0 full write, port 1 read back
    req = 2'b01; we = 2'b01; a0 = 4'd3; b0 = 4'hF; d0 = 32'hDEADBEEF;
    #1;
    check("wr_gnt", gnt, 2'b01);
    check("wr_we", ram_we, 1'b1);
    check("wr_addr", ram_addr, 4'd3);
    check("wr_din", ram_din, 32'hDEADBEEF);
    tick;
    req = 2'b10; we = 2'b00; a1 = 4'd3;
    #1;
    check("rd_gnt", gnt, 2'b10);
    check("wr_no_rvalid", rvalid, 2'b00);
    tick;
    req = 2'b00;
    check("rd_rvalid", rvalid, 2'b10);
    check("rd_rdata", rdata, 32'hDEADBEEF);

    // Byte-enabled write then read on port 0
    tick;
    req = 2'b01; we = 2'b01; a0 = 4'd5; b0 = 4'b0101; d0 = 32'hAABBCCDD;
    #1;
    check("be_wr_be", ram_be, 4'b0101);
    tick;
    we = 2'b00;
    tick;
    req = 2'b00;
    check("be_rvalid", rvalid, 2'b01);
    check("be_rdata", rdata, 32'h00BB00DD);

    // Idle bus: port-0 address, no write
    a0 = 4'd9; b0 = 4'hF; d0 = 32'hFFFFFFFF;
    #1;
    check("idle_gnt", gnt, 2'b00);
    check("idle_we", ram_we, 1'b0);
    check("idle_be", ram_be, 4'h0);
    check("idle_addr", ram_addr, 4'd9);
    check("idle_din", ram_din, 32'd0);

    // Last grant went to port 0, so port 1 wins the next tie
    req = 2'b11; a0 = 4'd1; a1 = 4'd2;
    #1;
    check("ptr_gnt", gnt, 2'b10);
    tick;
    req = 2'b00;

    // Reset during the fill restarts it from address 0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    check("mid_addr7", ram_addr, 4'd7);
    rst = 1'b1;
    tick;
    check("mid_rvalid", rvalid, 2'b00);
    check("mid_init_done", init_done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("refill_we", ram_we, 1'b1);
      check("refill_addr", ram_addr, i);
      tick;
    end
    check("refill_done", init_done, 1'b1);

    // No-fill instance: usable right after reset
    rst_nc = 1'b0; req_nc = 2'b01; a0_nc = 4'd0;
    #1;
    check("nc_init_done", init_done_nc, 1'b1);
    check("nc_gnt", gnt_nc, 2'b01);
    tick;
    req_nc = 2'b00;
    check("nc_rvalid", rvalid_nc, 2'b01);
    check("nc_rdata", rdata_nc, 32'h12345678);
    tick;
    check("nc_rvalid_end", rvalid_nc, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
